regfile_wb_arbiter: RTL and testbench

- Write-side front end of the register bank; it alone drives the bank's regwrite/rd/rd_data port.
- Merges two result streams onto that single write port:
  - single-cycle ALU results;
  - delayed load responses from data memory.
- Load data is extracted and sign- or zero-extended in the block, then buffered in a small FIFO until the port is free.
- Also reports per-register pending status so decode can stall on load-use hazards.

---
 rtl/rv_wb_pkg.sv | 48 ++++
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/wb_load_fifo.sv | 83 ++++++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_wb_pkg
// Description : Shared types and helpers for the register-bank write-back
//               path: load funct3 codes, the queued write entry, and the
//               load data extraction function.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry;

    // Select and extend the addressed byte/half of a little-endian word.
    // Unrecognised funct3 codes fall back to a full-word load.
    function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] word);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (addr_lo)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      v_res = {{24{v_byte[7]}}, v_byte};
            LBU:     v_res = {24'h000000, v_byte};
            LH:      v_res = {{16{v_half[15]}}, v_half};
            LHU:     v_res = {16'h0000, v_half};
            default: v_res = word;
        endcase
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bundle of the ALU result stream, the load response stream,
//               the register-bank write port and the hazard query port.
//               The arbiter uses the slave view, its driver the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    import rv_wb_pkg::*;

    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_word;
    logic        ld_ready;

    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_pending;
    logic        rs2_pending;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
        output ld_ready,
        output regwrite, rd, rd_data,
        input  q_rs1, q_rs2,
        output rs1_pending, rs2_pending
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
        input  ld_ready,
        input  regwrite, rd, rd_data,
        output q_rs1, q_rs2,
        input  rs1_pending, rs2_pending
    );

endinterface
`default_nettype wire

// File: rtl/wb_load_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_load_fifo
// Description : Circular buffer of pending load write-backs. Exposes the
//               occupancy count and a per-slot valid/rd view so the hazard
//               logic can see every queued destination register.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_load_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  push,
    input  wire wb_entry               push_entry,
    input  wire logic                  pop,
    output wb_entry                    head,
    output logic [AW:0]                count,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [DEPTH-1:0][4:0]      entry_rd
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    wb_entry          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [DEPTH-1:0] r_valid;
    logic             w_push;
    logic             w_pop;

    // Overflow and underflow are blocked here so a misbehaving caller
    // cannot corrupt the pointers.
    assign w_push = push && (r_count != c_full_count);
    assign w_pop  = pop  && (r_count != '0);

    // Storage array; data needs no reset since r_valid qualifies it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head        = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign entry_valid = r_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_rd
            assign entry_rd[gi] = r_mem[gi].rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Sole driver of the register-bank write port. Merges ALU
//               results with extracted load data buffered in a FIFO, and
//               reports per-register load-pending status for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [AW:0]          w_count;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_take_alu;
    wb_entry              w_push_entry;
    wb_entry              w_head;
    logic [DEPTH-1:0]     w_entry_valid;
    logic [DEPTH-1:0][4:0] w_entry_rd;
    logic                 w_rs1_hit;
    logic                 w_rs2_hit;

    logic                 r_regwrite;
    logic [4:0]           r_rd;
    logic [31:0]          r_rd_data;
    logic                 r_from_fifo;

    assign w_full        = (w_count == c_full_count);
    assign bus.ld_ready  = !w_full;
    assign bus.alu_ready = !w_full;

    // Loads to x0 are acknowledged but never occupy a FIFO slot.
    assign w_push            = bus.ld_valid && !w_full && (bus.ld_rd != 5'd0);
    assign w_push_entry.rd   = bus.ld_rd;
    assign w_push_entry.data = load_extract(bus.ld_funct3, bus.ld_addr_lo, bus.ld_word);

    // A full FIFO forces a drain; otherwise ALU results take precedence.
    assign w_take_alu = !w_full && bus.alu_valid;
    assign w_pop      = w_full || (!bus.alu_valid && (w_count != '0));

    wb_load_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (w_push),
        .push_entry  (w_push_entry),
        .pop         (w_pop),
        .head        (w_head),
        .count       (w_count),
        .entry_valid (w_entry_valid),
        .entry_rd    (w_entry_rd)
    );

    // Register the arbitration winner onto the bank write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regwrite  <= 1'b0;
            r_rd        <= 5'd0;
            r_rd_data   <= 32'd0;
            r_from_fifo <= 1'b0;
        end else if (w_pop) begin
            r_regwrite  <= 1'b1;
            r_rd        <= w_head.rd;
            r_rd_data   <= w_head.data;
            r_from_fifo <= 1'b1;
        end else if (w_take_alu && (bus.alu_rd != 5'd0)) begin
            r_regwrite  <= 1'b1;
            r_rd        <= bus.alu_rd;
            r_rd_data   <= bus.alu_data;
            r_from_fifo <= 1'b0;
        end else begin
            r_regwrite  <= 1'b0;
            r_from_fifo <= 1'b0;
        end
    end

    assign bus.regwrite = r_regwrite;
    assign bus.rd       = r_rd;
    assign bus.rd_data  = r_rd_data;

    // A register is pending while any queued load or the load being
    // written this cycle targets it.
    always_comb begin
        w_rs1_hit = r_regwrite && r_from_fifo && (r_rd == bus.q_rs1);
        w_rs2_hit = r_regwrite && r_from_fifo && (r_rd == bus.q_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && (w_entry_rd[i] == bus.q_rs1)) w_rs1_hit = 1'b1;
            if (w_entry_valid[i] && (w_entry_rd[i] == bus.q_rs2)) w_rs2_hit = 1'b1;
        end
    end

    assign bus.rs1_pending = (bus.q_rs1 != 5'd0) && w_rs1_hit;
    assign bus.rs2_pending = (bus.q_rs2 != 5'd0) && w_rs2_hit;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter with
//               hand-computed expected write-port values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import rv_wb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    regfile_wb_arbiter_if u_bus ();

    regfile_wb_arbiter #(
        .DEPTH (4),
        .AW    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        u_bus.alu_valid  = 1'b0;
        u_bus.alu_rd     = 5'd0;
        u_bus.alu_data   = 32'd0;
        u_bus.ld_valid   = 1'b0;
        u_bus.ld_rd      = 5'd0;
        u_bus.ld_funct3  = 3'd0;
        u_bus.ld_addr_lo = 2'd0;
        u_bus.ld_word    = 32'd0;
    endtask

    task automatic drive_load(input logic [4:0] rdi, input logic [2:0] f3,
                              input logic [1:0] lo, input logic [31:0] word);
        u_bus.ld_valid   = 1'b1;
        u_bus.ld_rd      = rdi;
        u_bus.ld_funct3  = f3;
        u_bus.ld_addr_lo = lo;
        u_bus.ld_word    = word;
    endtask

    task automatic drive_alu(input logic [4:0] rdi, input logic [31:0] data);
        u_bus.alu_valid = 1'b1;
        u_bus.alu_rd    = rdi;
        u_bus.alu_data  = data;
    endtask

    // Bounded wait for a lone load to reach the write port, then check it.
    task automatic expect_load_write(input string tag, input logic [4:0] exp_rd,
                                     input logic [31:0] exp_data);
        int k;
        k = 0;
        while (!u_bus.regwrite && k < 4) begin
            next_cycle();
            k++;
        end
        check({tag, "_we"},   {31'd0, u_bus.regwrite}, 32'd1);
        check({tag, "_rd"},   {27'd0, u_bus.rd}, {27'd0, exp_rd});
        check({tag, "_data"}, u_bus.rd_data, exp_data);
        next_cycle();
        next_cycle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        u_bus.q_rs1 = 5'd0;
        u_bus.q_rs2 = 5'd0;
        next_cycle();
        next_cycle();
        u_bus.q_rs1 = 5'd5;
        settle();
        check("rst_we",      {31'd0, u_bus.regwrite}, 32'd0);
        check("rst_rd",      {27'd0, u_bus.rd}, 32'd0);
        check("rst_data",    u_bus.rd_data, 32'd0);
        check("rst_ldrdy",   {31'd0, u_bus.ld_ready}, 32'd1);
        check("rst_alurdy",  {31'd0, u_bus.alu_ready}, 32'd1);
        check("rst_pend",    {31'd0, u_bus.rs1_pending}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Byte and half-word extraction
        drive_load(5'd5, LB, 2'd2, 32'h80FF_7F01);
        next_cycle();
        drive_idle();
        expect_load_write("lb", 5'd5, 32'hFFFF_FFFF);
        drive_load(5'd6, LBU, 2'd3, 32'h80FF_7F01);
        next_cycle();
        drive_idle();
        expect_load_write("lbu", 5'd6, 32'h0000_0080);
        drive_load(5'd7, LH, 2'd2, 32'h8001_1234);
        next_cycle();
        drive_idle();
        expect_load_write("lh", 5'd7, 32'hFFFF_8001);
        drive_load(5'd8, LHU, 2'd1, 32'h8001_1234);
        next_cycle();
        drive_idle();
        expect_load_write("lhu", 5'd8, 32'h0000_1234);
        drive_load(5'd9, LB, 2'd1, 32'h0000_7F00);
        next_cycle();
        drive_idle();
        expect_load_write("lb_pos", 5'd9, 32'h0000_007F);

        // ALU beats a simultaneous load; load follows one cycle later
        drive_alu(5'd3, 32'd7);
        drive_load(5'd4, LW, 2'd3, 32'hDEAD_BEEF);
        u_bus.q_rs1 = 5'd4;
        u_bus.q_rs2 = 5'd3;
        settle();
        check("pri_pend_c0", {31'd0, u_bus.rs1_pending}, 32'd0);
        next_cycle();
        drive_idle();
        settle();
        check("pri_c1_we",   {31'd0, u_bus.regwrite}, 32'd1);
        check("pri_c1_rd",   {27'd0, u_bus.rd}, 32'd3);
        check("pri_c1_data", u_bus.rd_data, 32'd7);
        check("pri_c1_pend", {31'd0, u_bus.rs1_pending}, 32'd1);
        check("pri_alu_nopend", {31'd0, u_bus.rs2_pending}, 32'd0);
        next_cycle();
        check("pri_c2_we",   {31'd0, u_bus.regwrite}, 32'd1);
        check("pri_c2_rd",   {27'd0, u_bus.rd}, 32'd4);
        check("pri_c2_data", u_bus.rd_data, 32'hDEAD_BEEF);
        check("pri_c2_pend", {31'd0, u_bus.rs1_pending}, 32'd1);
        next_cycle();
        check("pri_c3_we",   {31'd0, u_bus.regwrite}, 32'd0);
        check("pri_c3_pend", {31'd0, u_bus.rs1_pending}, 32'd0);
        next_cycle();

        // Fill the FIFO while the ALU keeps the port busy
        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(10 + i), 32'(100 + i));
            drive_load(5'(20 + i), LW, 2'd0, 32'(32'h1000 + i));
            settle();
            check("full_ldrdy_fill", {31'd0, u_bus.ld_ready}, 32'd1);
            next_cycle();
        end
        u_bus.ld_valid = 1'b0;
        drive_alu(5'd9, 32'h99);
        u_bus.q_rs1 = 5'd20;
        u_bus.q_rs2 = 5'd23;
        settle();
        check("full_ldrdy",  {31'd0, u_bus.ld_ready}, 32'd0);
        check("full_alurdy", {31'd0, u_bus.alu_ready}, 32'd0);
        check("full_last_alu_rd", {27'd0, u_bus.rd}, 32'd13);
        check("full_pend1",  {31'd0, u_bus.rs1_pending}, 32'd1);
        check("full_pend2",  {31'd0, u_bus.rs2_pending}, 32'd1);
        next_cycle();
        check("drain0_rd",   {27'd0, u_bus.rd}, 32'd20);
        check("drain0_data", u_bus.rd_data, 32'h1000);
        check("drain0_alurdy", {31'd0, u_bus.alu_ready}, 32'd1);
        check("drain0_ldrdy",  {31'd0, u_bus.ld_ready}, 32'd1);
        next_cycle();
        drive_idle();
        check("alu_after_full_rd",   {27'd0, u_bus.rd}, 32'd9);
        check("alu_after_full_data", u_bus.rd_data, 32'h99);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            check("drain_we",   {31'd0, u_bus.regwrite}, 32'd1);
            check("drain_rd",   {27'd0, u_bus.rd}, 32'(20 + i));
            check("drain_data", u_bus.rd_data, 32'(32'h1000 + i));
        end
        next_cycle();
        check("drain_done_we", {31'd0, u_bus.regwrite}, 32'd0);
        check("drain_done_pend", {31'd0, u_bus.rs2_pending}, 32'd0);

        // Writes to x0 and an undefined funct3
        drive_load(5'd0, LW, 2'd0, 32'h1234_5678);
        next_cycle();
        drive_idle();
        check("x0_ld_we_c1", {31'd0, u_bus.regwrite}, 32'd0);
        next_cycle();
        check("x0_ld_we_c2", {31'd0, u_bus.regwrite}, 32'd0);
        drive_alu(5'd0, 32'd5);
        next_cycle();
        drive_idle();
        check("x0_alu_we",   {31'd0, u_bus.regwrite}, 32'd0);
        check("x0_alu_rdhold", {27'd0, u_bus.rd}, 32'd23);
        u_bus.q_rs1 = 5'd0;
        drive_load(5'd0, LW, 2'd0, 32'h1);
        settle();
        check("x0_q_nopend", {31'd0, u_bus.rs1_pending}, 32'd0);
        next_cycle();
        drive_idle();
        drive_load(5'd7, 3'b111, 2'd1, 32'h8123_4567);
        next_cycle();
        drive_idle();
        expect_load_write("f3_111", 5'd7, 32'h8123_4567);

        // Reset while three loads sit in the FIFO
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'd1, 32'h11);
            drive_load(5'(11 + i), LW, 2'd0, 32'hBAD0_0000 + 32'(i));
            next_cycle();
        end
        drive_idle();
        u_bus.q_rs1 = 5'd11;
        u_bus.q_rs2 = 5'd13;
        settle();
        check("prerst_pend", {31'd0, u_bus.rs1_pending}, 32'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        settle();
        check("midrst_we",    {31'd0, u_bus.regwrite}, 32'd0);
        check("midrst_pend1", {31'd0, u_bus.rs1_pending}, 32'd0);
        check("midrst_pend2", {31'd0, u_bus.rs2_pending}, 32'd0);
        check("midrst_ldrdy", {31'd0, u_bus.ld_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("postrst_no_we", {31'd0, u_bus.regwrite}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
